// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed-latency request/response handshake.
// A request is accepted in IDLE, waits WAIT_CYCLES in BUSY, commits or reads in RESP and
// strobes rsp_valid in the cycle that follows. Sub-word accesses are right-aligned on reads
// and low-aligned on writes.
// Optional feature: define DMEM_RESP_ERR_CHECK_EN to flag out-of-range addresses and
// strobes that spill past lane 3 (rsp_err=1, no memory change, in_data_bus=0). Without it
// the word index wraps modulo DEPTH_WORDS, spilled strobe lanes are dropped and rsp_err=0.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_rw,
  input  logic [3:0]  mem_wstrobe,
  input  logic [31:0] out_addr_bus,
  input  logic [31:0] out_data_bus,
  output logic [31:0] in_data_bus,
  output logic        rsp_valid,
  output logic        rsp_err
);

  localparam int unsigned IdxW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitLd = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        rw_q;
  logic [3:0]  strb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_pend_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic            cur_rw;
  logic [3:0]      cur_strb;
  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic [31:0]     offset;
  logic [IdxW-1:0] idx;
  logic [7:0]      strb_wide;
  logic [31:0]     wdata_sh;
  logic [31:0]     rd_shifted;
  logic            req_err;
  logic            enter_resp;
  logic            mem_we;

  // Select the live inputs on an accept edge (WAIT_CYCLES=0 enters RESP directly), else the latch.
  always_comb begin
    if (state_q == StIdle) begin
      cur_rw    = mem_rw;
      cur_strb  = mem_wstrobe;
      cur_addr  = out_addr_bus;
      cur_wdata = out_data_bus;
    end else begin
      cur_rw    = rw_q;
      cur_strb  = strb_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  // Address decode, lane alignment and read-data alignment for the current request.
  always_comb begin
    offset     = cur_addr - BASE_ADDR;
    idx        = offset[IdxW+1:2];
    strb_wide  = {4'b0000, cur_strb} << cur_addr[1:0];
    wdata_sh   = cur_wdata << {cur_addr[1:0], 3'b000};
    rd_shifted = mem[idx] >> {cur_addr[1:0], 3'b000};
`ifdef DMEM_RESP_ERR_CHECK_EN
    // Addresses below BASE_ADDR wrap to huge offsets and fail the range compare too.
    req_err    = ({1'b0, offset} >= (33'(DEPTH_WORDS) << 2)) || (cur_rw && |strb_wide[7:4]);
`else
    req_err    = 1'b0;
`endif
  end

`ifndef DMEM_RESP_ERR_CHECK_EN
  logic unused_bits;
  assign unused_bits = ^{offset[31:IdxW+2], strb_wide[7:4]};
`endif

  // The edge entering RESP is where writes commit and read data is captured.
  always_comb begin
    enter_resp = ((state_q == StIdle) && req_valid && (WAIT_CYCLES == 0)) ||
                 ((state_q == StBusy) && (cnt_q == 4'd1));
    mem_we     = nreset && enter_resp && cur_rw && !req_err;
  end

  // Byte-lane memory write; storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_wide[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b0;
      strb_q      <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      err_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            rw_q    <= mem_rw;
            strb_q  <= mem_wstrobe;
            addr_q  <= out_addr_bus;
            wdata_q <= out_data_bus;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StBusy;
              cnt_q   <= WaitLd;
            end
          end
        end
        StBusy: begin
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_pend_q;
        end
        default: state_q <= StIdle;
      endcase
      if (enter_resp) begin
        err_pend_q <= req_err;
        if (req_err) begin
          rdata_q <= 32'd0;
        end else if (!cur_rw) begin
          rdata_q <= rd_shifted;
        end
      end
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign in_data_bus = rdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for function/latency and a
// WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        nreset;
  logic        req_valid, mem_rw;
  logic [3:0]  mem_wstrobe;
  logic [31:0] out_addr_bus, out_data_bus;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] in_data_bus;

  logic        req_valid0, mem_rw0;
  logic [3:0]  mem_wstrobe0;
  logic [31:0] out_addr_bus0, out_data_bus0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] in_data_bus0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_rw(mem_rw), .mem_wstrobe(mem_wstrobe), .out_addr_bus(out_addr_bus),
    .out_data_bus(out_data_bus), .in_data_bus(in_data_bus), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err)
  );

  dmem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .nreset(nreset), .req_valid(req_valid0), .req_ready(req_ready0),
    .mem_rw(mem_rw0), .mem_wstrobe(mem_wstrobe0), .out_addr_bus(out_addr_bus0),
    .out_data_bus(out_data_bus0), .in_data_bus(in_data_bus0), .rsp_valid(rsp_valid0),
    .rsp_err(rsp_err0)
  );

  // Issue one request to u_dut; lat counts edges after the accept edge until rsp_valid shows.
  // Inputs are scrambled after acceptance; the DUT must ignore them.
  task automatic do_req(input logic rw, input logic [3:0] strb, input logic [31:0] addr,
                        input logic [31:0] data, output int lat, output logic [31:0] rd,
                        output logic err);
    @(negedge clk);
    req_valid = 1'b1; mem_rw = rw; mem_wstrobe = strb; out_addr_bus = addr; out_data_bus = data;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_rw = ~rw; mem_wstrobe = 4'hF;
    out_addr_bus = 32'h8000_0000; out_data_bus = 32'hFFFF_FFFF;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rd  = in_data_bus;
    err = rsp_err;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    req_valid = 1'b0; mem_rw = 1'b0; mem_wstrobe = 4'h0; out_addr_bus = 32'h0; out_data_bus = 32'h0;
    req_valid0 = 1'b0; mem_rw0 = 1'b0; mem_wstrobe0 = 4'h0; out_addr_bus0 = 32'h0;
    out_data_bus0 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (in_data_bus !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", in_data_bus); end
    checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b want 1", req_ready0); end
    nreset = 1'b1;
  endtask

  task automatic test_word_rw();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, lat, rd, err);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_wr_latency: got %0d want 3", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL word_wr_err: got %b want 0", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL word_wr_rdata_hold: got %h want 0", rd); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle: got %b want 0", rsp_valid); end
    do_req(1'b0, 4'h0, 32'h8000_0010, 32'h0, lat, rd, err);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_rd_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_rd: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 4'hF, 32'h8000_0010, 32'h1122_3344, lat, rd, err);
    do_req(1'b1, 4'h1, 32'h8000_0013, 32'h0000_00AB, lat, rd, err);
    do_req(1'b0, 4'h0, 32'h8000_0010, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hAB22_3344) begin errors++; $display("FAIL byte_word: got %h want ab223344", rd); end
    do_req(1'b0, 4'h0, 32'h8000_0013, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL byte_rd3: got %h want 000000ab", rd); end
    do_req(1'b0, 4'h0, 32'h8000_0011, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h00AB_2233) begin errors++; $display("FAIL byte_rd1: got %h want 00ab2233", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 4'hF, 32'h8000_0020, 32'h0, lat, rd, err);
    do_req(1'b1, 4'h3, 32'h8000_0022, 32'h0000_1234, lat, rd, err);
    do_req(1'b0, 4'h0, 32'h8000_0020, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h1234_0000) begin errors++; $display("FAIL half_word: got %h want 12340000", rd); end
    do_req(1'b0, 4'h0, 32'h8000_0022, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL half_rd: got %h want 00001234", rd); end
  endtask

  task automatic test_zero_strobe();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 4'h0, 32'h8000_0020, 32'hFFFF_FFFF, lat, rd, err);
    checks++; if (lat !== 3) begin errors++; $display("FAIL zstrb_latency: got %0d want 3", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zstrb_err: got %b want 0", err); end
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL zstrb_rdata_hold: got %h want 00001234", rd); end
    do_req(1'b0, 4'h0, 32'h8000_0020, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h1234_0000) begin errors++; $display("FAIL zstrb_mem: got %h want 12340000", rd); end
  endtask

  task automatic test_reset_busy();
    int lat; int seen; logic [31:0] rd; logic err;
    do_req(1'b1, 4'hF, 32'h8000_0000, 32'hCAFE_0000, lat, rd, err);
    @(negedge clk);
    req_valid = 1'b1; mem_rw = 1'b1; mem_wstrobe = 4'hF;
    out_addr_bus = 32'h8000_0000; out_data_bus = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    nreset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL busy_reset_ready: got %b want 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL busy_reset_no_rsp: got %0d responses want 0", seen); end
    do_req(1'b0, 4'h0, 32'h8000_0000, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hCAFE_0000) begin errors++; $display("FAIL busy_reset_mem: got %h want cafe0000", rd); end
  endtask

  task automatic test_rdata_hold();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 4'h0, 32'h8000_0011, 32'h0, lat, rd, err);
    do_req(1'b1, 4'hF, 32'h8000_0040, 32'h7777_7777, lat, rd, err);
    checks++; if (rd !== 32'h00AB_2233) begin errors++; $display("FAIL wr_rdata_hold: got %h want 00ab2233", rd); end
  endtask

`ifdef DMEM_RESP_ERR_CHECK_EN
  task automatic test_errors();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_low_addr: got %b want 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_low_rdata: got %h want 0", rd); end
    do_req(1'b1, 4'hF, 32'h8000_0002, 32'h1234_5678, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_spill: got %b want 1", err); end
    do_req(1'b0, 4'h0, 32'h8000_0000, 32'h0, lat, rd, err);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_ok_read: got %b want 0", err); end
    checks++; if (rd !== 32'hCAFE_0000) begin errors++; $display("FAIL err_mem_kept: got %h want cafe0000", rd); end
  endtask
`else
  task automatic test_wrap();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 4'hF, 32'h8000_1030, 32'hA5A5_A5A5, lat, rd, err);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err); end
    do_req(1'b0, 4'h0, 32'h8000_0030, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wrap_rd: got %h want a5a5a5a5", rd); end
    do_req(1'b1, 4'h3, 32'h8000_0033, 32'h0000_BBCC, lat, rd, err);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL spill_err: got %b want 0", err); end
    do_req(1'b0, 4'h0, 32'h8000_0030, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hCCA5_A5A5) begin errors++; $display("FAIL spill_drop: got %h want cca5a5a5", rd); end
  endtask
`endif

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid0 = 1'b1; mem_rw0 = 1'b1; mem_wstrobe0 = 4'hF;
    out_addr_bus0 = 32'h8000_0004; out_data_bus0 = 32'h600D_F00D;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready0 !== 1'(k % 2)) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want %0d", k, req_ready0, k % 2);
      end
      checks++;
      if (rsp_valid0 !== 1'(k % 2)) begin
        errors++; $display("FAIL b2b_rsp_valid[%0d]: got %b want %0d", k, rsp_valid0, k % 2);
      end
    end
    mem_rw0 = 1'b0; out_addr_bus0 = 32'h8000_0005;
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 1'b0;
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL w0_rd_early: got %b want 0", rsp_valid0); end
    checks++; if (in_data_bus0 !== 32'h0060_0DF0) begin errors++; $display("FAIL w0_rd_data: got %h want 00600df0", in_data_bus0); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL w0_rd_rsp: got %b want 1", rsp_valid0); end
    checks++; if (rsp_err0 !== 1'b0) begin errors++; $display("FAIL w0_rd_err: got %b want 0", rsp_err0); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte();
    test_half();
    test_zero_strobe();
    test_reset_busy();
    test_rdata_hold();
`ifdef DMEM_RESP_ERR_CHECK_EN
    test_errors();
`else
    test_wrap();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h80000000, giving the byte address of word 0.
REQ-002 The module SHALL have parameter DEPTH_WORDS, default 1024, giving storage depth in 32-bit words (power of two).
REQ-003 The module SHALL have parameter WAIT_CYCLES, default 2, range 0..15, giving extra cycles between accept and response.
REQ-004 The module SHALL have one clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port nreset, input, 1, synchronous active-low reset.
REQ-007 Port req_valid, input, 1, request present.
REQ-008 Port req_ready, output, 1, responder can accept a request.
REQ-009 Port mem_rw, input, 1, 1 = write, 0 = read.
REQ-010 Port mem_wstrobe, input, 4, low-aligned byte-lane enables (0001 byte, 0011 half, 1111 word).
REQ-011 Port out_addr_bus, input, 32, byte address from the CPU.
REQ-012 Port out_data_bus, input, 32, low-aligned write data from the CPU.
REQ-013 Port in_data_bus, output, 32, registered read data, right-aligned to the addressed byte.
REQ-014 Port rsp_valid, output, 1, one-cycle response strobe.
REQ-015 Port rsp_err, output, 1, response carries an error; valid only with rsp_valid.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, req_valid=1 SHALL latch mem_rw, mem_wstrobe, out_addr_bus and out_data_bus, then go to BUSY when WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES) or to RESP when WAIT_CYCLES=0.
REQ-018 In BUSY the counter SHALL decrement each cycle, with the transition to RESP on the edge where it reaches 1.
REQ-019 For an accept edge at T, rsp_valid SHALL be 1 for exactly the cycle after edge T+1+WAIT_CYCLES; RESP SHALL return to IDLE on the next edge.
REQ-020 Peak throughput SHALL be one request per WAIT_CYCLES+2 cycles; input changes outside IDLE SHALL be ignored.
REQ-021 The word index SHALL be (addr-BASE_ADDR)>>2, and the byte offset SHALL be o=addr[1:0].
REQ-022 A write SHALL shift wstrobe left by o lanes and wdata left by 8*o bits, and SHALL commit only the enabled in-word lanes on the edge entering RESP.
REQ-023 A write with wstrobe=0000 SHALL leave memory unchanged and still respond normally.
REQ-024 A read SHALL register in_data_bus = word>>(8*o) on the edge entering RESP, with zero-fill in the upper bits.
REQ-025 in_data_bus SHALL hold its value until the next read response; a write response SHALL leave it unchanged.
REQ-026 A read accepted after a write response SHALL return the written data (read-after-write coherent).

Reset
REQ-027 While nreset=0 at a clock edge, the state SHALL become IDLE and the counter 0, with rsp_valid=0, rsp_err=0, in_data_bus=0 and req_ready=1 after that edge.
REQ-028 Reset in BUSY SHALL abort the request: the pending write SHALL NOT be committed and no response SHALL be issued.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMEM_RESP_ERR_CHECK_EN defined: an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), or a write whose shifted strobe exceeds lane 3, SHALL respond with rsp_err=1, no memory change and in_data_bus=0.
REQ-031 Macro DMEM_RESP_ERR_CHECK_EN undefined: the index SHALL wrap modulo DEPTH_WORDS, shifted strobe bits beyond lane 3 SHALL be dropped, and rsp_err SHALL be tied 0.

Verification
REQ-032 With WAIT_CYCLES=2, write 0xDEADBEEF, strobe 1111 at 0x80000010 accepted at edge 0 -> rsp_valid in the cycle after edge 3 only; a read of 0x80000010 then returns 0xDEADBEEF.
REQ-033 Write 0x000000AB, strobe 0001 at 0x80000013 over 0x11223344 -> word becomes 0xAB223344; a read at 0x80000013 returns 0x000000AB.
REQ-034 Write 0x00001234, strobe 0011 at 0x80000022 over 0 -> word 0x12340000; a read at 0x80000022 returns 0x00001234.
REQ-035 req_valid held high continuously with WAIT_CYCLES=0 -> accepts on every second edge; req_ready=0 in RESP.
REQ-036 nreset=0 in BUSY on a write of 0x55 to 0x80000000 -> no rsp_valid; a subsequent read returns the old word.
REQ-037 With DMEM_RESP_ERR_CHECK_EN, a read of 0x7FFFFFFC -> rsp_err=1, in_data_bus=0; a word write at 0x80000002 -> rsp_err=1 and memory unchanged.
